// File: rtl/seq_detector_param_if.sv
// Serial-stream and configuration bundle for seq_detector_param.
// master drives bits and config; slave returns the match flag and count.
interface seq_detector_param_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   localparam int LW = $clog2(PAT_W + 1);

   logic             in;
   logic             in_valid;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LW-1:0]    cfg_len;
   logic             cfg_overlap;
   logic             out;
   logic [CNT_W-1:0] match_count;

   modport master (
      output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      input  out, match_count
   );

   modport slave (
      input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      output out, match_count
   );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector, Moore output, saturating count.
// SEQ_DET_DEBUG_EN adds dbg_hist / dbg_fill / dbg_state observation ports.
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] DEF_PAT = 'b101,
   parameter int               DEF_LEN = 3,
   parameter bit               DEF_OVL = 1'b1
) (
   input logic                 clock,
   input logic                 reset,
   seq_detector_param_if.slave bus
`ifdef SEQ_DET_DEBUG_EN
   ,
   output logic [PAT_W-1:0]              dbg_hist,
   output logic [$clog2(PAT_W+1)-1:0]    dbg_fill,
   output logic [0:0]                    dbg_state
`endif
);
   localparam int LW = $clog2(PAT_W + 1);

   typedef enum logic {HUNT = 1'b0, MATCH = 1'b1} state_t;

   state_t           state;
   state_t           state_n;
   logic [PAT_W-1:0] pat;
   logic [LW-1:0]    len;
   logic             ovl;
   logic [PAT_W-1:0] hist;
   logic [LW-1:0]    fill;
   logic [CNT_W-1:0] cnt;

   logic [PAT_W-1:0] mask;
   logic [PAT_W-1:0] hist_sh;
   logic [LW-1:0]    fill_inc;
   logic [LW-1:0]    len_ld;
   logic             accept;
   logic             hit;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (LW'(i) < len);
      end
      hist_sh  = {hist[PAT_W-2:0], bus.in};
      fill_inc = (fill >= len) ? len : fill + 1'b1;
      accept   = bus.in_valid & ~bus.cfg_load;
      hit      = accept && (fill_inc == len)
                 && (((hist_sh ^ pat) & mask) == '0);
   end

   // Out-of-range lengths are clamped into 1..PAT_W at load time
   always_comb begin
      len_ld = bus.cfg_len;
      if (bus.cfg_len == '0) begin
         len_ld = LW'(1);
      end else if (bus.cfg_len > LW'(PAT_W)) begin
         len_ld = LW'(PAT_W);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pat  <= DEF_PAT;
         len  <= LW'(DEF_LEN);
         ovl  <= DEF_OVL;
         hist <= '0;
         fill <= '0;
         cnt  <= '0;
      end else if (bus.cfg_load) begin
         pat  <= bus.cfg_pattern;
         len  <= len_ld;
         ovl  <= bus.cfg_overlap;
         hist <= '0;
         fill <= '0;
         cnt  <= '0;
      end else if (accept) begin
         hist <= hist_sh;
         fill <= (hit && !ovl) ? '0 : fill_inc;
         if (hit && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= HUNT;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = HUNT;
      unique case (state)
         HUNT:    state_n = hit ? MATCH : HUNT;
         MATCH:   state_n = hit ? MATCH : HUNT;
         default: state_n = HUNT;
      endcase
   end

   always_comb begin
      bus.out         = (state == MATCH);
      bus.match_count = cnt;
   end

`ifdef SEQ_DET_DEBUG_EN
   always_comb begin
      dbg_hist  = hist;
      dbg_fill  = fill;
      dbg_state = (state == MATCH);
   end
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param: two instances (CNT_W 8 and 2)
// share one stimulus stream; expectations flow through a scoreboard queue.
module tb_seq_detector_param;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       d_in, d_vld, d_ld, d_ovl;
   logic [3:0] d_pat;
   logic [2:0] d_len;

   seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) ia ();
   seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) ib ();

   assign ia.in          = d_in;
   assign ia.in_valid    = d_vld;
   assign ia.cfg_load    = d_ld;
   assign ia.cfg_pattern = d_pat;
   assign ia.cfg_len     = d_len;
   assign ia.cfg_overlap = d_ovl;
   assign ib.in          = d_in;
   assign ib.in_valid    = d_vld;
   assign ib.cfg_load    = d_ld;
   assign ib.cfg_pattern = d_pat;
   assign ib.cfg_len     = d_len;
   assign ib.cfg_overlap = d_ovl;

`ifdef SEQ_DET_DEBUG_EN
   logic [3:0] ha, hb;
   logic [2:0] fa, fb;
   logic [0:0] sa, sb;
`endif

   seq_detector_param #(.PAT_W(4), .CNT_W(8)) ua (
      .clock(clk), .reset(rst), .bus(ia.slave)
`ifdef SEQ_DET_DEBUG_EN
      , .dbg_hist(ha), .dbg_fill(fa), .dbg_state(sa)
`endif
   );

   seq_detector_param #(.PAT_W(4), .CNT_W(2)) ub (
      .clock(clk), .reset(rst), .bus(ib.slave)
`ifdef SEQ_DET_DEBUG_EN
      , .dbg_hist(hb), .dbg_fill(fb), .dbg_state(sb)
`endif
   );

   typedef struct {
      logic       rst, ld;
      logic [3:0] pat;
      logic [2:0] len;
      logic       ovl, vld, din, eo;
      int         ec;
   } vec_t;

   typedef struct {
      logic eo;
      int   ec;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic vec_t mk(logic r, logic l, logic [3:0] p,
                               logic [2:0] n, logic o, logic v,
                               logic d, logic eo, int ec);
      vec_t t;
      t.rst = r; t.ld = l; t.pat = p; t.len = n; t.ovl = o;
      t.vld = v; t.din = d; t.eo = eo; t.ec = ec;
      return t;
   endfunction

   function automatic vec_t rs();
      return mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
   endfunction

   function automatic vec_t bt(logic d, logic eo, int ec);
      return mk(0, 0, 0, 0, 0, 1, d, eo, ec);
   endfunction

   function automatic vec_t gap(int ec);
      return mk(0, 0, 0, 0, 0, 0, 1, 0, ec);
   endfunction

   function automatic vec_t ld(logic [3:0] p, logic [2:0] n, logic o);
      return mk(0, 1, p, n, o, 0, 0, 0, 0);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic step(vec_t t, string nm);
      exp_t e;
      rst = t.rst; d_ld = t.ld; d_pat = t.pat; d_len = t.len;
      d_ovl = t.ovl; d_vld = t.vld; d_in = t.din;
      e.eo = t.eo; e.ec = t.ec;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({nm, " scoreboard empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({nm, " out8"}, int'(ia.out), int'(e.eo));
         chk({nm, " cnt8"}, int'(ia.match_count), e.ec);
         chk({nm, " out2"}, int'(ib.out), int'(e.eo));
         chk({nm, " cnt2"}, int'(ib.match_count), (e.ec > 3) ? 3 : e.ec);
      end
   endtask

   initial begin
      rst = 1; d_ld = 0; d_pat = 0; d_len = 0;
      d_ovl = 0; d_vld = 0; d_in = 0;

      // defaults 101, overlap
      tbl.push_back(rs());
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(bt(1, 1, 1));
      tbl.push_back(bt(0, 0, 1));
      tbl.push_back(bt(1, 1, 2));
      tbl.push_back(gap(2));
      // 1101 non-overlap, then overlap
      tbl.push_back(ld(4'b1101, 3'd4, 0));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(bt(1, 1, 1));
      tbl.push_back(bt(1, 0, 1));
      tbl.push_back(bt(0, 0, 1));
      tbl.push_back(bt(1, 0, 1));
      tbl.push_back(ld(4'b1101, 3'd4, 1));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(bt(1, 1, 1));
      tbl.push_back(bt(1, 0, 1));
      tbl.push_back(bt(0, 0, 1));
      tbl.push_back(bt(1, 1, 2));
      // valid gaps hold history
      tbl.push_back(rs());
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(gap(0));
      tbl.push_back(gap(0));
      tbl.push_back(gap(0));
      tbl.push_back(bt(1, 1, 1));
      tbl.push_back(gap(1));
      // len 0 -> 1, saturation on the CNT_W=2 instance
      tbl.push_back(ld(4'b0001, 3'd0, 1));
      tbl.push_back(bt(1, 1, 1));
      tbl.push_back(bt(1, 1, 2));
      tbl.push_back(bt(1, 1, 3));
      tbl.push_back(bt(1, 1, 4));
      tbl.push_back(bt(1, 1, 5));
      tbl.push_back(bt(0, 0, 5));
      tbl.push_back(gap(5));
      // len 7 -> 4
      tbl.push_back(ld(4'b1010, 3'd7, 1));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 0, 0));
      tbl.push_back(bt(1, 0, 0));
      tbl.push_back(bt(0, 1, 1));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // reset lands on the cycle a hit would complete
      step(rs(), "r6_rst");
      step(bt(1, 0, 0), "r6_b1");
      step(bt(0, 0, 0), "r6_b0");
      step(mk(1, 0, 0, 0, 0, 1, 1, 0, 0), "r6_rst_hit");
      step(bt(1, 0, 0), "r6_after");

      // cfg_load beats a simultaneous valid bit and clears history
      step(rs(), "l6_rst");
      step(bt(1, 0, 0), "l6_b1");
      step(bt(0, 0, 0), "l6_b0");
      step(mk(0, 1, 4'b0101, 3'd3, 1, 1, 1, 0, 0), "l6_ld");
      step(bt(0, 0, 0), "l6_c0");
      step(bt(1, 0, 0), "l6_c1");
      step(bt(0, 0, 0), "l6_c2");
      step(bt(1, 1, 1), "l6_c3");

      if (sb.size() != 0) chk("scoreboard drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
